data_memory_interface: RTL and testbench



---
 rtl/data_memory_interface_if.sv | 31 +++
 rtl/data_memory_interface.sv | 149 ++++++++++++++
 tb/tb_data_memory_interface.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_interface_if.sv
// Data-memory bus bundle between the load/store unit (master) and memory (slave).
// Master drives request/write/address/data/strobe; slave returns ready and read data.
interface data_memory_interface_if;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_write_strobe;
  logic        bus_ready;
  logic [31:0] bus_read_data;

  modport master (
    output bus_request,
    output bus_write,
    output bus_address,
    output bus_write_data,
    output bus_write_strobe,
    input  bus_ready,
    input  bus_read_data
  );

  modport slave (
    input  bus_request,
    input  bus_write,
    input  bus_address,
    input  bus_write_data,
    input  bus_write_strobe,
    output bus_ready,
    output bus_read_data
  );
endinterface

// File: rtl/data_memory_interface.sv
// Load/store bus adapter: accepts one request, stalls the core until the bus completes,
// right-aligns load data by byte offset, and aborts hung transactions via a watchdog.
// Ports: clk, reset (async, active-high); core side memory_read/memory_write/funct3/
// address/data_memory_write_data/write_mask in, data_memory_read_data/memory_busy out;
// bus (master modport); bus_error and misaligned_access one-cycle pulses in DONE.
// Optional: define MISALIGN_CHECK_EN to reject misaligned loads and mask-0 stores
// with a misaligned_access pulse.
module data_memory_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNTER_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] data_memory_write_data,
  input  logic [3:0]  write_mask,
  output logic [31:0] data_memory_read_data,
  output logic        memory_busy,
  data_memory_interface_if.master bus,
  output logic        bus_error,
  output logic        misaligned_access
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [COUNTER_WIDTH:0] TMO =
    (COUNTER_WIDTH+1)'(TIMEOUT_CYCLES);

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] count;
  logic [COUNTER_WIDTH:0]   count_next;
  logic                     timeout;
  logic                     req_read;
  logic [1:0]               req_off;
  logic [4:0]               shamt;
  logic [31:0]              aligned;
  logic                     mis_rd;
  logic                     mis_wr;
  logic                     skip;

  // count_next is the number of REQ cycles elapsed including this one
  assign count_next = {1'b0, count} + (COUNTER_WIDTH+1)'(1);
  assign timeout    = (TIMEOUT_CYCLES != 0) && (count_next >= TMO);

  assign shamt   = {req_off, 3'b000};
  assign aligned = bus.bus_read_data >> shamt;

  // A mask-0 store never reaches the bus in either build
  assign mis_wr = memory_write && !memory_read
               && (write_mask == 4'b0000);

`ifdef MISALIGN_CHECK_EN
  assign mis_rd = memory_read && (
      ((funct3[1:0] == 2'b01) && address[0])
   || ((funct3 == 3'b010) && (address[1:0] != 2'b00)));
`else
  logic unused_funct3;
  assign unused_funct3     = ^funct3;
  assign mis_rd            = 1'b0;
  assign misaligned_access = 1'b0;
`endif

  assign skip = mis_rd || mis_wr;

  always_comb begin
    memory_busy = 1'b0;
    unique case (state)
      IDLE:    memory_busy = memory_read | memory_write;
      REQ:     memory_busy = 1'b1;
      DONE:    memory_busy = 1'b0;
      default: memory_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      count                 <= '0;
      req_read              <= 1'b0;
      req_off               <= 2'b00;
      data_memory_read_data <= '0;
      bus.bus_request       <= 1'b0;
      bus.bus_write         <= 1'b0;
      bus.bus_address       <= '0;
      bus.bus_write_data    <= '0;
      bus.bus_write_strobe  <= '0;
      bus_error             <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misaligned_access     <= 1'b0;
`endif
    end else begin
      bus_error <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misaligned_access <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          count <= '0;
          if (memory_read || memory_write) begin
            req_read             <= memory_read;
            req_off              <= address[1:0];
            bus.bus_address      <= {address[31:2], 2'b00};
            bus.bus_write        <= !memory_read;
            bus.bus_write_data   <= data_memory_write_data;
            bus.bus_write_strobe <= memory_read ? 4'b0000
                                               : write_mask;
            if (skip) begin
              state <= DONE;
              if (mis_rd) data_memory_read_data <= '0;
`ifdef MISALIGN_CHECK_EN
              misaligned_access <= 1'b1;
`endif
            end else begin
              state           <= REQ;
              bus.bus_request <= 1'b1;
            end
          end
        end
        REQ: begin
          count <= count + COUNTER_WIDTH'(1);
          // bus_ready takes precedence over a same-cycle timeout
          if (bus.bus_ready) begin
            bus.bus_request <= 1'b0;
            if (req_read) data_memory_read_data <= aligned;
            state <= DONE;
          end else if (timeout) begin
            bus.bus_request       <= 1'b0;
            data_memory_read_data <= '0;
            bus_error             <= 1'b1;
            state                 <= DONE;
          end
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_interface.sv
// Self-checking bench for data_memory_interface: directed cases plus random
// transactions on a default instance and a TIMEOUT_CYCLES=4 instance.
module tb_data_memory_interface;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        rd, wr, rdy;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, rdat;
  logic [3:0]  mask;

  data_memory_interface_if bus0 ();
  data_memory_interface_if bus1 ();

  assign bus0.bus_ready     = rdy & ~sel;
  assign bus0.bus_read_data = rdat;
  assign bus1.bus_ready     = rdy & sel;
  assign bus1.bus_read_data = rdat;

  logic [31:0] dm0, dm1;
  logic        busy0, busy1, err0, err1, mis0, mis1;

  data_memory_interface u_dut (
    .clk                    (clk),
    .reset                  (reset),
    .memory_read            (rd & ~sel),
    .memory_write           (wr & ~sel),
    .funct3                 (f3),
    .address                (addr),
    .data_memory_write_data (wdata),
    .write_mask             (mask),
    .data_memory_read_data  (dm0),
    .memory_busy            (busy0),
    .bus                    (bus0),
    .bus_error              (err0),
    .misaligned_access      (mis0)
  );

  data_memory_interface #(.TIMEOUT_CYCLES(4)) u_tmo (
    .clk                    (clk),
    .reset                  (reset),
    .memory_read            (rd & sel),
    .memory_write           (wr & sel),
    .funct3                 (f3),
    .address                (addr),
    .data_memory_write_data (wdata),
    .write_mask             (mask),
    .data_memory_read_data  (dm1),
    .memory_busy            (busy1),
    .bus                    (bus1),
    .bus_error              (err1),
    .misaligned_access      (mis1)
  );

  wire        o_req  = sel ? bus1.bus_request      : bus0.bus_request;
  wire        o_wr   = sel ? bus1.bus_write        : bus0.bus_write;
  wire [31:0] o_addr = sel ? bus1.bus_address      : bus0.bus_address;
  wire [31:0] o_wd   = sel ? bus1.bus_write_data   : bus0.bus_write_data;
  wire [3:0]  o_stb  = sel ? bus1.bus_write_strobe : bus0.bus_write_strobe;
  wire [31:0] o_dm   = sel ? dm1   : dm0;
  wire        o_busy = sel ? busy1 : busy0;
  wire        o_err  = sel ? err1  : err0;
  wire        o_mis  = sel ? mis1  : mis0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_data [2];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; the bus answers in REQ cycle d+1 (never if d is large).
  task automatic txn(input bit s, input bit r, input bit w,
                     input logic [2:0] fn, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] m,
                     input int d, input logic [31:0] bd);
    int          tmo;
    bit          skip, mis, to, done, saw_req;
    int          exp_busy, nb;
    logic [31:0] exp_rd;
    tmo  = s ? 4 : 255;
    skip = !r && w && (m == 4'b0000);
    mis  = 1'b0;
    to   = 1'b0;
`ifdef MISALIGN_CHECK_EN
    if (r && (((fn == 3'b001 || fn == 3'b101) && a[0] == 1'b1)
           || (fn == 3'b010 && a[1:0] != 2'b00))) begin
      mis  = 1'b1;
      skip = 1'b1;
    end
    if (!r && w && m == 4'b0000) mis = 1'b1;
`endif
    exp_rd = exp_data[s];
    if (skip) begin
      exp_busy = 1;
      if (r) exp_rd = 32'h0;
    end else if (d >= tmo) begin
      exp_busy = tmo + 1;
      to       = 1'b1;
      exp_rd   = 32'h0;
    end else begin
      exp_busy = d + 2;
      if (r) exp_rd = bd / (32'd1 << (8 * a[1:0]));
    end

    @(posedge clk); #1;
    sel = s; rd = r; wr = w; f3 = fn; addr = a;
    wdata = wd; mask = m; rdy = 1'b0; rdat = bd;
    @(negedge clk);
    check("accept_busy", {31'b0, o_busy}, 32'd1);
    check("accept_noreq", {31'b0, o_req}, 32'd0);

    done    = 1'b0;
    saw_req = 1'b0;
    nb      = 0;
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk); #1;
      rdy = (j == d + 1);
      @(negedge clk);
      if (!o_busy) begin
        done = 1'b1;
        nb   = j;
        break;
      end
      saw_req = saw_req | o_req;
      if (j == 1) begin
        check("req_valid", {31'b0, o_req}, 32'd1);
        check("req_addr", o_addr, {a[31:2], 2'b00});
        check("req_write", {31'b0, o_wr}, {31'b0, !r});
        check("req_strobe", {28'b0, o_stb}, r ? 32'd0 : {28'b0, m});
        if (!r) check("req_wdata", o_wd, wd);
      end
    end
    check("done_reached", {31'b0, done}, 32'd1);
    check("busy_cycles", nb, exp_busy);
    check("bus_used", {31'b0, saw_req}, {31'b0, !skip});
    check("done_data", o_dm, exp_rd);
    check("done_err", {31'b0, o_err}, {31'b0, to});
    check("done_mis", {31'b0, o_mis}, {31'b0, mis});
    check("done_noreq", {31'b0, o_req}, 32'd0);
    exp_data[s] = exp_rd;

    rd = 1'b0; wr = 1'b0; rdy = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_busy", {31'b0, o_busy}, 32'd0);
    check("idle_err", {31'b0, o_err}, 32'd0);
    check("idle_data", o_dm, exp_rd);
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; rdy = 1'b0;
    f3 = 3'b0; addr = 32'h0; wdata = 32'h0; mask = 4'h0; rdat = 32'h0;
    exp_data[0] = 32'h0;
    exp_data[1] = 32'h0;
    #12;
    check("rst_req", {31'b0, o_req}, 32'd0);
    check("rst_addr", o_addr, 32'h0);
    check("rst_strobe", {28'b0, o_stb}, 32'd0);
    check("rst_data", o_dm, 32'h0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_err", {31'b0, o_err}, 32'd0);
    check("rst_mis", {31'b0, o_mis}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // load with offset 3 answered on the first REQ cycle
    txn(0, 1, 0, 3'b100, 32'h103, 32'h0, 4'hf, 0, 32'hAABBCCDD);
    // store answered in the fifth REQ cycle
    txn(0, 0, 1, 3'b010, 32'h202, 32'h12341234, 4'b1100, 4, 32'h5555AAAA);
    // mask-0 store never touches the bus
    txn(0, 0, 1, 3'b000, 32'h300, 32'hDEADBEEF, 4'b0000, 0, 32'h0);
    // watchdog instance: good load, then a load that times out
    txn(1, 1, 0, 3'b000, 32'h40, 32'h0, 4'h0, 0, 32'h87654321);
    txn(1, 1, 0, 3'b000, 32'h44, 32'h0, 4'h0, 1000, 32'h0);
    // bus_ready on the same cycle the watchdog would fire
    txn(1, 1, 0, 3'b010, 32'h48, 32'h0, 4'h0, 3, 32'hCAFEF00D);

    // reset asserted mid-REQ
    @(posedge clk); #1;
    sel = 1'b0; rd = 1'b1; f3 = 3'b010; addr = 32'h80; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    rd    = 1'b0;
    #1;
    check("midrst_req", {31'b0, o_req}, 32'd0);
    check("midrst_busy", {31'b0, o_busy}, 32'd0);
    check("midrst_data", o_dm, 32'h0);
    exp_data[0] = 32'h0;
    exp_data[1] = 32'h0;
    #1;
    reset = 1'b0;
    txn(0, 1, 0, 3'b010, 32'h84, 32'h0, 4'h0, 1, 32'h0BADC0DE);

    // LW at a misaligned address
    txn(0, 1, 0, 3'b010, 32'h001, 32'h0, 4'h0, 0, 32'h11223344);

    for (int k = 0; k < 40; k++) begin
      bit          s, r, w;
      logic [3:0]  m;
      int          sel_rw;
      s      = 1'($urandom_range(0, 1));
      sel_rw = $urandom_range(0, 4);
      r      = (sel_rw == 0 || sel_rw == 1 || sel_rw == 4);
      w      = (sel_rw == 2 || sel_rw == 3 || sel_rw == 4);
      m      = ($urandom_range(0, 4) == 0) ? 4'h0
             : 4'($urandom_range(1, 15));
      txn(s, r, w, 3'($urandom_range(0, 7)), $urandom,
          $urandom, m, $urandom_range(0, 6), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
